// File: rtl/lcd_pkg.sv
// Shared definitions for the lcd_term HD44780 character terminal:
// refresh FSM states, controller init commands, DDRAM row bases, codes.
package lcd_pkg;

    // Per-byte transfer states; ST_INIT is the sequencer's power-up phase.
    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD
    } lcd_state_t;

    // Top-level sequencing phase of the refresh engine.
    typedef enum logic [1:0] {
        PH_INIT,
        PH_IDLE,
        PH_PASS
    } seq_phase_t;

    // Function set 8-bit/2-line, display on, clear, entry mode increment.
    localparam logic [7:0] INIT_CMDS [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    // DDRAM start address of each display row.
    localparam logic [7:0] ROW_BASE [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

    localparam logic [7:0] CR_CODE    = 8'h0D;
    localparam logic [7:0] BS_CODE    = 8'h08;
    localparam logic [7:0] SPACE_CODE = 8'h20;

endpackage

// File: rtl/lcd_strobe.sv
// One HD44780 bus transfer: SETUP (1 cycle) latches data/rs, PULSE holds
// lcd_en high for EN_CYCLES, HOLD waits CMD_DELAY cycles. done pulses in
// the final cycle; a new start is taken only while idle.
module lcd_strobe
    import lcd_pkg::*;
#(
    parameter int unsigned EN_CYCLES = 16,
    parameter int unsigned CMD_DELAY = 262143
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       tx_rs,
    output logic       idle,
    output logic       done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_en
);

    lcd_state_t  state, state_next;
    logic [31:0] cnt;

    // State register, phase counter and latched bus values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            lcd_data <= '0;
            lcd_rs   <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state || state == ST_IDLE)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (state == ST_IDLE && start) begin
                lcd_data <= tx_data;
                lcd_rs   <= tx_rs;
            end
        end
    end

    // Next-state decode and completion strobe.
    always_comb begin
        state_next = state;
        done       = 1'b0;
        unique case (state)
            ST_IDLE:  if (start) state_next = ST_SETUP;
            ST_SETUP: state_next = ST_PULSE;
            ST_PULSE: begin
                if (cnt == 32'(EN_CYCLES - 1)) begin
                    if (CMD_DELAY == 0) begin
                        done       = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt == 32'(CMD_DELAY - 1)) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign idle   = (state == ST_IDLE);
    // Decoded from the asynchronously reset state, so reset drops it at once.
    assign lcd_en = (state == ST_PULSE);

endmodule

// File: rtl/lcd_term.sv
// Character terminal on an HD44780 LCD: keeps a ROWS x COLS text buffer
// with cursor, wrap and scroll, and continuously mirrors it to the panel.
// Optional macro LCD_TERM_BACKSPACE_EN enables 0x08 backspace handling.
module lcd_term
    import lcd_pkg::*;
#(
    parameter int unsigned ROWS      = 2,
    parameter int unsigned COLS      = 16,
    parameter int unsigned EN_CYCLES = 16,
    parameter int unsigned CMD_DELAY = 262143
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       write_en,
    input  logic [7:0] data,
    output logic       ready,
    output logic       busy,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic       lcd_rw,
    output logic       lcd_on,
    output logic       lcd_blon
);

    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned PW = $clog2(COLS + 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [PW-1:0] PASS_END = PW'(COLS);

    logic [7:0]    char_buf [ROWS][COLS];
    logic [7:0]    snap     [ROWS][COLS];
    logic [RW-1:0] cur_row, scr_idx, scr_next;
    logic [CW-1:0] cur_col;
    logic          pending_wrap, scrolling, pend_valid;
    logic [7:0]    pend_char;
    logic          accept, is_print, buf_mod;

    seq_phase_t    phase, phase_next;
    logic [1:0]    init_idx;
    logic [RW-1:0] prow;
    logic [PW-1:0] pslot;
    logic          dirty, pass_begin;
    logic          stb_start, stb_idle, stb_done;
    logic [7:0]    tx_byte;
    logic          tx_rs;

    assign ready    = !scrolling;
    assign busy     = (phase != PH_IDLE);
    assign lcd_rw   = 1'b0;
    assign lcd_on   = 1'b1;
    assign lcd_blon = 1'b1;
    assign scr_next = scr_idx + 1'b1;

    // Classify the incoming byte and flag any buffer modification this cycle.
    always_comb begin
        accept   = write_en && !scrolling;
        is_print = (data >= 8'h20) && (data <= 8'h7E);
        buf_mod  = scrolling;
        if (accept) begin
            if (is_print || data == CR_CODE) buf_mod = 1'b1;
`ifdef LCD_TERM_BACKSPACE_EN
            if (data == BS_CODE) buf_mod = 1'b1;
`endif
        end
    end

    // Text buffer, cursor and row-by-row scroll. A printable byte that wraps
    // onto a scroll is parked in pend_char and dropped into column 0 of the
    // freshly blanked last row in the scroll's final cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < ROWS; r++)
                for (int unsigned c = 0; c < COLS; c++)
                    char_buf[r][c] <= SPACE_CODE;
            cur_row      <= '0;
            cur_col      <= '0;
            pending_wrap <= 1'b0;
            scrolling    <= 1'b0;
            scr_idx      <= '0;
            pend_valid   <= 1'b0;
            pend_char    <= '0;
        end else if (scrolling) begin
            if (ROWS > 1) begin
                char_buf[scr_idx] <= char_buf[scr_next];
                if (scr_idx == RW'(ROWS - 2)) begin
                    for (int unsigned c = 0; c < COLS; c++)
                        char_buf[LAST_ROW][c] <= (c == 0 && pend_valid) ? pend_char : SPACE_CODE;
                    if (pend_valid) cur_col <= CW'(1);
                    scrolling  <= 1'b0;
                    pend_valid <= 1'b0;
                end else begin
                    scr_idx <= scr_next;
                end
            end
        end else if (accept) begin
            if (is_print) begin
                if (pending_wrap) begin
                    pending_wrap <= 1'b0;
                    if (cur_row != LAST_ROW) begin
                        cur_row                      <= cur_row + 1'b1;
                        char_buf[cur_row + 1'b1][0]  <= data;
                        cur_col                      <= CW'(1);
                    end else if (ROWS == 1) begin
                        for (int unsigned c = 0; c < COLS; c++)
                            char_buf[0][c] <= (c == 0) ? data : SPACE_CODE;
                        cur_col <= CW'(1);
                    end else begin
                        scrolling  <= 1'b1;
                        scr_idx    <= '0;
                        pend_valid <= 1'b1;
                        pend_char  <= data;
                        cur_col    <= '0;
                    end
                end else begin
                    char_buf[cur_row][cur_col] <= data;
                    if (cur_col == LAST_COL) pending_wrap <= 1'b1;
                    else                     cur_col      <= cur_col + 1'b1;
                end
            end else if (data == CR_CODE) begin
                pending_wrap <= 1'b0;
                cur_col      <= '0;
                if (cur_row != LAST_ROW) begin
                    cur_row <= cur_row + 1'b1;
                end else if (ROWS == 1) begin
                    for (int unsigned c = 0; c < COLS; c++)
                        char_buf[0][c] <= SPACE_CODE;
                end else begin
                    scrolling  <= 1'b1;
                    scr_idx    <= '0;
                    pend_valid <= 1'b0;
                end
            end
`ifdef LCD_TERM_BACKSPACE_EN
            else if (data == BS_CODE) begin
                if (pending_wrap) begin
                    pending_wrap               <= 1'b0;
                    char_buf[cur_row][cur_col] <= SPACE_CODE;
                end else if (cur_col != '0) begin
                    cur_col                           <= cur_col - 1'b1;
                    char_buf[cur_row][cur_col - 1'b1] <= SPACE_CODE;
                end else begin
                    char_buf[cur_row][0] <= SPACE_CODE;
                end
            end
`endif
        end
    end

    // Freeze the buffer at pass start so later edits cannot tear a pass.
    always_ff @(posedge clock) begin
        if (pass_begin) snap <= char_buf;
    end

    // Sequencer phase, byte position and dirty flag; a same-cycle edit wins
    // over the pass-start clear so it is never lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase    <= PH_INIT;
            init_idx <= '0;
            prow     <= '0;
            pslot    <= '0;
            dirty    <= 1'b0;
        end else begin
            phase <= phase_next;
            if (buf_mod)         dirty <= 1'b1;
            else if (pass_begin) dirty <= 1'b0;
            if (phase == PH_INIT && stb_done) init_idx <= init_idx + 1'b1;
            if (pass_begin) begin
                prow  <= '0;
                pslot <= '0;
            end else if (phase == PH_PASS && stb_done) begin
                if (pslot == PASS_END) begin
                    pslot <= '0;
                    if (prow != LAST_ROW) prow <= prow + 1'b1;
                end else begin
                    pslot <= pslot + 1'b1;
                end
            end
        end
    end

    // Next phase and the byte offered to the strobe.
    always_comb begin
        phase_next = phase;
        pass_begin = 1'b0;
        stb_start  = 1'b0;
        tx_byte    = '0;
        tx_rs      = 1'b0;
        unique case (phase)
            PH_INIT: begin
                tx_byte   = INIT_CMDS[init_idx];
                stb_start = stb_idle;
                if (stb_done && init_idx == 2'd3) begin
                    phase_next = PH_PASS;
                    pass_begin = 1'b1;
                end
            end
            PH_IDLE: begin
                if (dirty) begin
                    phase_next = PH_PASS;
                    pass_begin = 1'b1;
                end
            end
            PH_PASS: begin
                if (pslot == '0) begin
                    tx_byte = 8'h80 | ROW_BASE[2'(prow)];
                end else begin
                    tx_byte = snap[prow][CW'(pslot - 1'b1)];
                    tx_rs   = 1'b1;
                end
                stb_start = stb_idle;
                if (stb_done && prow == LAST_ROW && pslot == PASS_END) begin
                    if (dirty) pass_begin = 1'b1;
                    else       phase_next = PH_IDLE;
                end
            end
            default: phase_next = PH_INIT;
        endcase
    end

    lcd_strobe #(
        .EN_CYCLES (EN_CYCLES),
        .CMD_DELAY (CMD_DELAY)
    ) u_strobe (
        .clock    (clock),
        .reset    (reset),
        .start    (stb_start),
        .tx_data  (tx_byte),
        .tx_rs    (tx_rs),
        .idle     (stb_idle),
        .done     (stb_done),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_en   (lcd_en)
    );

endmodule

// File: doc/lcd_term.md
LCD_TERM -- requirements
Module: lcd_term

Interface
REQ-001 Parameter ROWS, default 2, number of display rows (legal range 1..4).
REQ-002 Parameter COLS, default 16, characters per row (legal range 8..40).
REQ-003 Parameter EN_CYCLES, default 16, clock cycles lcd_en is held high per transfer.
REQ-004 Parameter CMD_DELAY, default 262143, idle clock cycles after each transfer.
REQ-005 clock  input  1  system clock; all state changes occur on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 write_en  input  1  character strobe; data is accepted only when write_en and ready are both high.
REQ-008 data  input  8  ASCII character or control code.
REQ-009 ready  output  1  high when the block can accept a character this cycle.
REQ-010 busy  output  1  high while the init sequence or a refresh pass is in progress.
REQ-011 lcd_data  output  8  HD44780 data bus.
REQ-012 lcd_rs  output  1  register select: 0 selects a command, 1 selects character data.
REQ-013 lcd_en  output  1  enable strobe.
REQ-014 lcd_rw, lcd_on, lcd_blon  output  1 each  driven constant 0, 1 and 1 respectively.

Function
REQ-015 Character buffer: ROWS x COLS bytes, every byte initialised to 0x20, plus cursor row, cursor column and a pending_wrap flag.
REQ-016 Printable character (0x20..0x7E), accepted:
- If pending_wrap is set, perform a newline first and clear pending_wrap.
- Store the character at the cursor and mark the buffer dirty.
- If the column was COLS-1, set pending_wrap; otherwise increment the column.
REQ-017 Newline operation: column becomes 0; if row is less than ROWS-1, row increments; otherwise scroll.
REQ-018 Scroll: row r takes the contents of row r+1, the last row is filled with 0x20, and the cursor row is unchanged.
REQ-019 A scroll takes ROWS-1 cycles, one row copied per cycle; ready is low for the duration of the scroll.
REQ-020 0x0D: perform a newline, clear pending_wrap and mark the buffer dirty.
REQ-021 All other codes are accepted and ignored, except as stated in REQ-033.
REQ-022 ready is low only during a scroll; it is not gated by the refresh engine.
REQ-023 Refresh engine FSM states: INIT, IDLE, SETUP, PULSE, HOLD.
- SETUP (1 cycle): drive lcd_data and lcd_rs.
- PULSE (EN_CYCLES cycles): lcd_en high.
- HOLD (CMD_DELAY cycles): lcd_en low.
- After HOLD, advance to the next byte.
REQ-024 INIT issues commands 0x38, 0x0C, 0x01, 0x06 once after reset, then does a full refresh pass.
REQ-025 Refresh pass, for each row r from 0 to ROWS-1:
- Issue the address command 0x80 | base[r], with base = {0x00, 0x40, 0x14, 0x54}.
- Then send COLS character bytes from buffer row r.
REQ-026 Dirty flag:
- Cleared at the start of each pass.
- Set on any buffer modification.
- Modifications during a pass leave the current pass unaffected.
REQ-027 At the end of a pass: if dirty is set, start a new pass from row 0 without repeating INIT; otherwise go to IDLE.
REQ-028 A modification in the same cycle as the end of a pass is captured and triggers a new pass.
REQ-029 lcd_data and lcd_rs remain stable from SETUP through the end of HOLD.
REQ-030 busy is high in every state except IDLE.

Reset
REQ-031 On reset:
- Buffer set to all 0x20, cursor at (0,0), pending_wrap=0, dirty=0.
- FSM enters INIT with counters at 0.
- lcd_en=0, lcd_data=0x00, lcd_rs=0, ready=1, busy=1.
REQ-032 Reset asserted mid-transfer drops lcd_en in the same cycle (asynchronously) and restarts INIT.

Configuration
REQ-033 Macro LCD_TERM_BACKSPACE_EN:
- Defined: 0x08 clears pending_wrap if it is set; otherwise it decrements the column (saturating at 0). It then writes 0x20 at the cursor and marks the buffer dirty.
- Undefined: 0x08 is ignored.

Structure
REQ-034 Shared package lcd_pkg holds:
- The refresh FSM state enum.
- Init command constants 0x38, 0x0C, 0x01, 0x06.
- The row base address table.
- The CR, BS and space code constants.
REQ-035 Sub-module lcd_strobe performs one SETUP/PULSE/HOLD transfer with a start/done handshake, parameterised by EN_CYCLES and CMD_DELAY.

Verification
REQ-036 Test parameters EN_CYCLES=2, CMD_DELAY=4.
- Stimulus: release reset.
- Required: bytes 0x38, 0x0C, 0x01, 0x06, 0x80, then 16 x 0x20, 0xC0, then 16 x 0x20; each byte has exactly 2 enable-high cycles; busy then falls.
REQ-037 Stimulus: write "AB", CR, "C".
- Required: final pass sends row 0 as "AB" plus 14 spaces, and row 1 as "C" plus 15 spaces.
REQ-038 Stimulus: write 17 'x' characters with ROWS=2, COLS=16.
- Required: row 0 is 16 x 'x'; row 1 is 'x' followed by 15 spaces; no scroll occurs.
REQ-039 Stimulus: write CR, CR, "Z" with ROWS=2.
- Required: ready low for 1 cycle during the scroll; row 0 all spaces; row 1 "Z" plus 15 spaces.
REQ-040 Stimulus: write 'Q' during the 10th byte of a pass.
- Required: the current pass completes unchanged, then exactly one additional pass shows 'Q'.
REQ-041 Stimulus, with LCD_TERM_BACKSPACE_EN defined: write "AB", 0x08.
- Required: row 0 is 'A' plus 15 spaces, cursor column 1.
- Same stimulus without the macro: row 0 remains "AB".
